control_seq: RTL

Parametrised successor to the Mini SRC hardwired control unit. Same multi-cycle fetch/decode/execute sequencing, datapath strobes and ALU one-hot encoding. Adds:
- a memory-ready handshake with a programmable timeout,
- single-step mode,
- a retired-instruction counter,
- a sticky memory-error flag.

Sits between the IR/CON logic and the datapath, bus encoders, register file select logic and RAM.

---
 rtl/control_seq.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/control_seq.sv
// Hardwired multi-cycle control sequencer: fetch/decode/execute strobes with a
// memory-ready handshake and timeout, single-step mode and a retired counter.
module control_seq #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             step_go,
  input  logic             mem_done,
  input  logic             CON,
  input  logic [4:0]       IRop,
  output logic             clr,
  output logic             CONin,
  output logic             RAM_wr,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic [15:0]      DPin,
  output logic [15:0]      DPout,
  output logic [15:0]      ALUopp,
  output logic             run,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned DpPc = 0, DpIr = 1, DpY = 2, DpMar = 3, DpMdr = 4, DpInport = 5;
  localparam int unsigned DpOutport = 6, DpZ = 7, DpZhi = 8, DpZlo = 9, DpHi = 10, DpLo = 11;
  localparam int unsigned DpRead = 12, DpC = 13;

  localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluNeg = 4'd2, AluMul = 4'd3;
  localparam logic [3:0] AluDiv = 4'd4, AluAnd = 4'd5, AluOr = 4'd6, AluRor = 4'd7;
  localparam logic [3:0] AluRol = 4'd8, AluSll = 4'd9, AluSra = 4'd10, AluSrl = 4'd11;
  localparam logic [3:0] AluNot = 4'd12, AluInc = 4'd13;

  localparam logic [4:0] OpLd = 5'd0, OpLdi = 5'd1, OpSt = 5'd2, OpAdd = 5'd3, OpSub = 5'd4;
  localparam logic [4:0] OpAnd = 5'd5, OpOr = 5'd6, OpRor = 5'd7, OpRol = 5'd8, OpShr = 5'd9;
  localparam logic [4:0] OpShra = 5'd10, OpShl = 5'd11, OpAddi = 5'd12, OpAndi = 5'd13;
  localparam logic [4:0] OpOri = 5'd14, OpDiv = 5'd15, OpMul = 5'd16, OpNeg = 5'd17;
  localparam logic [4:0] OpNot = 5'd18, OpBr = 5'd19, OpJal = 5'd20, OpJr = 5'd21;
  localparam logic [4:0] OpIn = 5'd22, OpOut = 5'd23, OpMflo = 5'd24, OpMfhi = 5'd25;
  localparam logic [4:0] OpHalt = 5'd27;

  localparam bit TimeoutEn = (MEM_TIMEOUT != 0);

  typedef enum logic [4:0] {
    StReset, StT0, StT1, StT2, StT3,
    StT4Alu, StT4Imm, StT4Un, StT5Alu,
    StT4Md, StT5Md, StT6Md,
    StT4Br, StT5Br, StT6Br,
    StT4Ld, StT5Ld, StT6Ld, StT7Ld,
    StT4Ldi, StT5Ldi,
    StT4St, StT5St, StT6St, StT7St,
    StT4Jal, StHalt
  } state_e;

  state_e           r_state;
  state_e           w_next;
  state_e           w_state_d;
  logic [TO_W-1:0]  r_wait;
  logic [3:0]       r_alu_op;
  logic [3:0]       w_alu_dec;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_retired;
  logic             w_mem;
  logic             w_go;
  logic             w_timeout;

  assign w_go      = !step_mode || step_go;
  assign w_timeout = TimeoutEn && w_mem && !mem_done && (r_wait == TO_W'(MEM_TIMEOUT));
  assign mem_err   = r_mem_err;
  assign retired   = r_retired;

  always_comb begin
    unique case (IRop)
      OpSub:          w_alu_dec = AluSub;
      OpAnd, OpAndi:  w_alu_dec = AluAnd;
      OpOr, OpOri:    w_alu_dec = AluOr;
      OpRor:          w_alu_dec = AluRor;
      OpRol:          w_alu_dec = AluRol;
      OpShr:          w_alu_dec = AluSrl;
      OpShra:         w_alu_dec = AluSra;
      OpShl:          w_alu_dec = AluSll;
      OpDiv:          w_alu_dec = AluDiv;
      OpMul:          w_alu_dec = AluMul;
      OpNeg:          w_alu_dec = AluNeg;
      OpNot:          w_alu_dec = AluNot;
      default:        w_alu_dec = AluAdd;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_mem  = 1'b0;
    unique case (r_state)
      StReset: w_next = StT0;
      StT0:    if (w_go) w_next = StT1;
      StT1: begin
        w_mem = 1'b1;
        if (mem_done) w_next = StT2;
      end
      StT2: w_next = StT3;
      StT3: begin
        case (IRop) inside
          [OpAdd:OpShl]:  w_next = StT4Alu;
          [OpAddi:OpOri]: w_next = StT4Imm;
          OpNeg, OpNot:   w_next = StT4Un;
          OpDiv, OpMul:   w_next = StT4Md;
          OpBr:           w_next = StT4Br;
          OpLd:           w_next = StT4Ld;
          OpLdi:          w_next = StT4Ldi;
          OpSt:           w_next = StT4St;
          OpJal:          w_next = StT4Jal;
          OpHalt:         w_next = StHalt;
          default:        w_next = StT0;
        endcase
      end
      StT4Alu, StT4Imm, StT4Un: w_next = StT5Alu;
      StT4Md:  w_next = StT5Md;
      StT5Md:  w_next = StT6Md;
      StT4Br:  w_next = CON ? StT5Br : StT0;
      StT5Br:  w_next = StT6Br;
      StT4Ld:  w_next = StT5Ld;
      StT5Ld:  w_next = StT6Ld;
      StT6Ld: begin
        w_mem = 1'b1;
        if (mem_done) w_next = StT7Ld;
      end
      StT4Ldi: w_next = StT5Ldi;
      StT4St:  w_next = StT5St;
      StT5St:  w_next = StT6St;
      StT6St:  w_next = StT7St;
      StT7St: begin
        w_mem = 1'b1;
        if (mem_done) w_next = StT0;
      end
      StT5Alu, StT6Md, StT6Br, StT7Ld, StT5Ldi, StT4Jal: w_next = StT0;
      StHalt:  w_next = StHalt;
      default: w_next = StReset;
    endcase
  end

  // Treset always proceeds to T0; elsewhere stop outranks a memory timeout.
  always_comb begin
    if (r_state == StReset)  w_state_d = StT0;
    else if (stop)           w_state_d = StHalt;
    else if (w_timeout)      w_state_d = StHalt;
    else                     w_state_d = w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StReset;
      r_wait    <= '0;
      r_alu_op  <= AluAdd;
      r_mem_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_d;
      r_wait  <= (w_mem && (w_state_d == r_state)) ? r_wait + TO_W'(1) : '0;
      if (r_state == StT3) r_alu_op <= w_alu_dec;
      if (w_timeout && !stop) r_mem_err <= 1'b1;
      if (w_state_d == StT0 && r_state != StT0 && r_state != StReset) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    clr    = 1'b0;
    CONin  = 1'b0;
    RAM_wr = 1'b0;
    Gra    = 1'b0;
    Grb    = 1'b0;
    Grc    = 1'b0;
    Rin    = 1'b0;
    Rout   = 1'b0;
    BAout  = 1'b0;
    DPin   = '0;
    DPout  = '0;
    ALUopp = 16'(1) << r_alu_op;
    run    = 1'b1;
    unique case (r_state)
      StReset: clr = 1'b1;
      StT0: begin
        ALUopp = 16'(1) << AluInc;
        if (w_go) begin
          DPout[DpPc] = 1'b1;
          DPin[DpMar] = 1'b1;
          DPin[DpZ]   = 1'b1;
        end
      end
      StT1: begin
        DPout[DpZlo] = 1'b1;
        DPin[DpPc]   = 1'b1;
        DPin[DpMdr]  = 1'b1;
        DPin[DpRead] = 1'b1;
      end
      StT2: begin
        DPout[DpMdr] = 1'b1;
        DPin[DpIr]   = 1'b1;
      end
      StT3: begin
        case (IRop) inside
          [OpAdd:OpShl], [OpAddi:OpOri]: begin Grb = 1'b1; Rout = 1'b1; DPin[DpY] = 1'b1; end
          OpDiv, OpMul: begin Gra = 1'b1; Rout = 1'b1; DPin[DpY] = 1'b1; end
          OpBr:         begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OpLd, OpLdi, OpSt: begin Grb = 1'b1; BAout = 1'b1; DPin[DpY] = 1'b1; end
          OpJal:  begin Grb = 1'b1; Rin = 1'b1; DPout[DpPc] = 1'b1; end
          OpJr:   begin Gra = 1'b1; Rout = 1'b1; DPin[DpPc] = 1'b1; end
          OpIn:   begin Gra = 1'b1; Rin = 1'b1; DPout[DpInport] = 1'b1; end
          OpOut:  begin Gra = 1'b1; Rout = 1'b1; DPin[DpOutport] = 1'b1; end
          OpMflo: begin Gra = 1'b1; Rin = 1'b1; DPout[DpLo] = 1'b1; end
          OpMfhi: begin Gra = 1'b1; Rin = 1'b1; DPout[DpHi] = 1'b1; end
          default: ;
        endcase
      end
      StT4Alu: begin Grc = 1'b1; Rout = 1'b1; DPin[DpZ] = 1'b1; end
      StT4Un, StT4Md: begin Grb = 1'b1; Rout = 1'b1; DPin[DpZ] = 1'b1; end
      StT4Imm, StT5Br, StT4Ld, StT4Ldi, StT4St: begin DPout[DpC] = 1'b1; DPin[DpZ] = 1'b1; end
      StT5Alu, StT5Ldi: begin DPout[DpZlo] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      StT5Md: begin DPout[DpZlo] = 1'b1; DPin[DpLo] = 1'b1; end
      StT6Md: begin DPout[DpZhi] = 1'b1; DPin[DpHi] = 1'b1; end
      StT4Br: begin
        if (CON) begin
          DPout[DpPc] = 1'b1;
          DPin[DpY]   = 1'b1;
        end
      end
      StT6Br: begin DPout[DpZlo] = 1'b1; DPin[DpPc] = 1'b1; end
      StT5Ld, StT5St: begin DPout[DpZlo] = 1'b1; DPin[DpMar] = 1'b1; end
      StT6Ld: begin DPin[DpMdr] = 1'b1; DPin[DpRead] = 1'b1; end
      StT7Ld: begin DPout[DpMdr] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      StT6St: begin Gra = 1'b1; Rout = 1'b1; DPin[DpMdr] = 1'b1; end
      StT7St: RAM_wr = 1'b1;
      StT4Jal: begin Gra = 1'b1; Rout = 1'b1; DPin[DpPc] = 1'b1; end
      StHalt: run = 1'b0;
      default: ;
    endcase
  end

endmodule
